sd_spi_card_model: RTL
======================

// Module: sd_spi_card_model
// PURPOSE
// - SPI-mode SD card responder: the card-side end of the SPI link driven by sd_ctrl_top.
// - Decodes command frames on sd_mosi and returns R1/R7/OCR responses.
// - Serves single-block reads (CMD17) and writes (CMD24) from an internal byte RAM.
// - Used in loopback benches and FPGA self-test in place of a physical card.
// PARAMETERS
// MEM_SECTORS   8    number of 512-byte sectors held in internal RAM
// ACMD41_TRIES  2    ACMD41 count that still returns idle (0x01) before reporting ready (0x00)
// NAC_BYTES     2    0xFF bytes between the CMD17 R1 and the 0xFE data token
// BUSY_BYTES    4    0x00 busy bytes after a CMD24 data response
// PORTS
// clk            in   1   model clock; must run >= 8x the sd_clk frequency
// rst_n          in   1   asynchronous active-low reset
// sd_clk         in   1   SPI clock from the host, mode 0
// sd_cs          in   1   chip select, active low
// sd_mosi        in   1   host-to-card data
// sd_miso        out  1   card-to-host data; 1 when idle or deselected
// init_done      out  1   1 after ACMD41 has returned 0x00
// last_cmd       out  6   index of the last complete command frame
// rd_blk_cnt     out  16  completed CMD17 transfers (wraps at 0xFFFF)
// wr_blk_cnt     out  16  completed CMD24 transfers (wraps at 0xFFFF)
// BEHAVIOUR
// - Reset values: sd_miso=1, init_done=0, last_cmd=0, counters=0, FSM=HUNT, idle flag=1. RAM is not cleared.
// - Input sync and edge detection:
//   - sd_clk, sd_cs and sd_mosi each pass through 2-flop synchronisers.
//   - Rising edge of synced sd_clk: sample mosi.
//   - Falling edge: shift the tx register; sd_miso = tx MSB.
// - Byte framing:
//   - A 3-bit counter counts rising edges while cs is low.
//   - Every 8th rising edge completes an rx byte and loads the next tx byte.
//   - That tx byte's MSB is driven on the following falling edge.
// - cs high (synced):
//   - Bit counter cleared, tx reg = 0xFF, FSM -> HUNT.
//   - Any transfer in progress is aborted. Write bytes already stored remain; no counter increments.
// - FSM states: HUNT, CMD, NCR, RESP, RD_NAC, RD_TOK, RD_DATA, RD_CRC, WR_TOK, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
// - HUNT:
//   - An rx byte matching 01xxxxxx starts a frame -> CMD.
//   - All other bytes are ignored; tx stays 0xFF.
// - CMD:
//   - Collects 5 more bytes: arg[31:0], then CRC.
//   - CRC is ignored; the stop bit is not checked.
//   - On the 6th byte: last_cmd updated -> NCR.
// - NCR: one 0xFF byte -> RESP.
// - RESP: R1 bit0 = idle flag. Response per command:
//   - CMD0: clears init_done, sets idle flag; R1=0x01.
//   - CMD8: R1, then 00 00 01 arg[7:0].
//   - CMD55: R1; arms the ACMD flag for the next frame only.
//   - ACMD41: the first ACMD41_TRIES calls return 0x01. Later calls clear idle, set init_done, return 0x00.
//   - CMD58: R1, then C0 FF 80 00 (CCS=1, block addressing).
//   - CMD17/CMD24 while idle=1: R1=0x05 (illegal), then HUNT.
//   - CMD17/CMD24 with arg >= MEM_SECTORS: R1=0x40 (parameter error), then HUNT.
//   - Any other index: R1 = 0x04 | idle.
// - Read path:
//   - CMD17 OK: R1=0x00 -> NAC_BYTES x 0xFF -> 0xFE -> 512 bytes.
//   - Data is RAM[arg*512 .. +511], ascending -> FF FF CRC -> rd_blk_cnt++ -> HUNT.
// - Write path:
//   - CMD24 OK: R1=0x00 -> WR_TOK waits for rx 0xFE; 0xFF bytes are ignored.
//   - WR_DATA: 512 bytes written ascending, one RAM write per byte.
//   - WR_CRC: 2 bytes ignored.
//   - WR_RESP: 0x05.
//   - WR_BUSY: BUSY_BYTES x 0x00, then wr_blk_cnt++ -> HUNT.
// - Counters: 16-bit counters wrap. The ACMD41 try counter saturates; it is cleared by CMD0 and rst_n.
// - Mid-operation rst_n assertion: all outputs immediately return to their reset values.
// TESTING
// - CMD0 (40 00000000 95) -> bytes FF 01; last_cmd=0; init_done=0.
// - CMD8 arg 0x1AA -> FF 01 00 00 01 AA.
// - CMD55+ACMD41 x3 -> R1 sequence 01, 01, 00; init_done=1.
// - CMD24 sector 3 with data = i[7:0] -> R1 00, response 05, 4 busy bytes 00; wr_blk_cnt=1.
// - CMD17 sector 3 -> 00 FF FF FE 00 01 .. FF (x2 pattern) FF FF; rd_blk_cnt=1.
// - Error cases:
//   - CMD17 before init -> 05.
//   - CMD17 sector 8 -> 40.
//   - cs raised after 100 write bytes -> next CMD0 answers 01; wr_blk_cnt unchanged.

Source files
------------

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: decodes host command frames, returns R1/R7/OCR responses
// and serves single-block reads and writes from an internal sector RAM.
module sd_spi_card_model #(
   parameter int unsigned MEM_SECTORS  = 8,
   parameter int unsigned ACMD41_TRIES = 2,
   parameter int unsigned NAC_BYTES    = 2,
   parameter int unsigned BUSY_BYTES   = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        sd_clk_i,
   input  logic        sd_cs_i,
   input  logic        sd_mosi_i,
   output logic        sd_miso_o,
   output logic        init_done_o,
   output logic [5:0]  last_cmd_o,
   output logic [15:0] rd_blk_cnt_o,
   output logic [15:0] wr_blk_cnt_o
);

   localparam int unsigned SecW  = (MEM_SECTORS > 1) ? $clog2(MEM_SECTORS) : 1;
   localparam int unsigned Bytes = MEM_SECTORS * 512;

   typedef enum logic [3:0] {
      StHunt, StCmd, StNcr, StResp, StRdNac, StRdTok, StRdData, StRdCrc,
      StWrTok, StWrData, StWrCrc, StWrResp, StWrBusy
   } state_e;

   logic [1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic        sclk_prev_q;
   logic        sclk_rise, sclk_fall;

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  rx_sr_q, rx_sr_d;
   logic [7:0]  tx_q, tx_d;
   logic        miso_q, miso_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [5:0]  cmd_q, cmd_d, last_cmd_q, last_cmd_d;
   logic [31:0] arg_q, arg_d;
   logic [7:0]  r1_q, r1_d;
   logic        idle_q, idle_d, init_q, init_d, acmd_q, acmd_d;
   logic [7:0]  tries_q, tries_d;
   logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

   logic [7:0]      mem [Bytes];
   logic [7:0]      rd_data_q;
   logic [SecW+8:0] mem_addr;
   logic            mem_we;
   logic [7:0]      rx_byte, r1, trail;
   logic            byte_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b11;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], sd_clk_i};
         cs_sync_q   <= {cs_sync_q[0], sd_cs_i};
         mosi_sync_q <= {mosi_sync_q[0], sd_mosi_i};
         sclk_prev_q <= sclk_sync_q[1];
      end
   end

   assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
   assign rx_byte   = {rx_sr_q, mosi_sync_q[1]};
   assign mem_addr  = {arg_q[SecW-1:0], cnt_q[8:0]};

   // Address is stable for many clocks before each byte boundary, so a registered read suffices.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[mem_addr] <= rx_byte;
      end
      rd_data_q <= mem[mem_addr];
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_d       = tx_q;
      miso_d     = miso_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      last_cmd_d = last_cmd_q;
      arg_d      = arg_q;
      r1_d       = r1_q;
      idle_d     = idle_q;
      init_d     = init_q;
      acmd_d     = acmd_q;
      tries_d    = tries_q;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      mem_we     = 1'b0;
      byte_done  = 1'b0;
      r1         = {7'd0, idle_q};
      trail      = 8'hFF;

      if (cs_sync_q[1]) begin
         bit_cnt_d = 3'd0;
         tx_d      = 8'hFF;
         miso_d    = 1'b1;
         state_d   = StHunt;
      end else begin
         if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b1};
         end
         if (sclk_rise) begin
            rx_sr_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_done = (bit_cnt_q == 3'd7);
         end
      end

      // tx_d loaded here is the byte the host clocks in during the next byte slot.
      if (byte_done) begin
         tx_d = 8'hFF;
         unique case (state_q)
            StHunt: begin
               if (rx_byte[7:6] == 2'b01) begin
                  cmd_d   = rx_byte[5:0];
                  cnt_d   = 10'd0;
                  state_d = StCmd;
               end
            end
            StCmd: begin
               if (cnt_q == 10'd4) begin
                  last_cmd_d = cmd_q;
                  state_d    = StNcr;
               end else begin
                  arg_d = {arg_q[23:0], rx_byte};
                  cnt_d = cnt_q + 10'd1;
               end
            end
            StNcr: begin
               acmd_d = (cmd_q == 6'd55);
               case (cmd_q)
                  6'd0: begin
                     idle_d  = 1'b1;
                     init_d  = 1'b0;
                     tries_d = 8'd0;
                     r1      = 8'h01;
                  end
                  6'd8, 6'd55, 6'd58: r1 = {7'd0, idle_q};
                  6'd17, 6'd24: begin
                     if (idle_q)                           r1 = 8'h05;
                     else if (arg_q >= 32'(MEM_SECTORS))   r1 = 8'h40;
                     else                                  r1 = 8'h00;
                  end
                  6'd41: begin
                     if (!acmd_q) begin
                        r1 = 8'h04 | {7'd0, idle_q};
                     end else if (tries_q < 8'(ACMD41_TRIES)) begin
                        tries_d = tries_q + 8'd1;
                        r1      = 8'h01;
                     end else begin
                        idle_d = 1'b0;
                        init_d = 1'b1;
                        r1     = 8'h00;
                     end
                  end
                  default: r1 = 8'h04 | {7'd0, idle_q};
               endcase
               r1_d    = r1;
               tx_d    = r1;
               cnt_d   = 10'd0;
               state_d = StResp;
            end
            StResp: begin
               if (cmd_q == 6'd8) begin
                  case (cnt_q[1:0])
                     2'd0, 2'd1: trail = 8'h00;
                     2'd2:       trail = 8'h01;
                     default:    trail = arg_q[7:0];
                  endcase
               end else begin
                  case (cnt_q[1:0])
                     2'd0:    trail = 8'hC0;
                     2'd1:    trail = 8'hFF;
                     2'd2:    trail = 8'h80;
                     default: trail = 8'h00;
                  endcase
               end
               if ((cmd_q == 6'd8 || cmd_q == 6'd58) && cnt_q < 10'd4) begin
                  tx_d  = trail;
                  cnt_d = cnt_q + 10'd1;
               end else if (cmd_q == 6'd17 && r1_q == 8'h00) begin
                  cnt_d   = 10'd0;
                  state_d = StRdNac;
               end else if (cmd_q == 6'd24 && r1_q == 8'h00) begin
                  state_d = StWrTok;
               end else begin
                  state_d = StHunt;
               end
            end
            StRdNac: begin
               if (cnt_q + 10'd1 >= 10'(NAC_BYTES)) begin
                  tx_d    = 8'hFE;
                  cnt_d   = 10'd0;
                  state_d = StRdTok;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
            StRdTok: begin
               tx_d    = rd_data_q;
               cnt_d   = 10'd1;
               state_d = StRdData;
            end
            StRdData: begin
               if (cnt_q == 10'd512) begin
                  cnt_d   = 10'd0;
                  state_d = StRdCrc;
               end else begin
                  tx_d  = rd_data_q;
                  cnt_d = cnt_q + 10'd1;
               end
            end
            StRdCrc: begin
               if (cnt_q == 10'd0) begin
                  cnt_d = 10'd1;
               end else begin
                  rd_cnt_d = rd_cnt_q + 16'd1;
                  state_d  = StHunt;
               end
            end
            StWrTok: begin
               if (rx_byte == 8'hFE) begin
                  cnt_d   = 10'd0;
                  state_d = StWrData;
               end
            end
            StWrData: begin
               mem_we = 1'b1;
               if (cnt_q == 10'd511) begin
                  cnt_d   = 10'd0;
                  state_d = StWrCrc;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
            StWrCrc: begin
               if (cnt_q == 10'd0) begin
                  cnt_d = 10'd1;
               end else begin
                  tx_d    = 8'h05;
                  state_d = StWrResp;
               end
            end
            StWrResp: begin
               tx_d    = 8'h00;
               cnt_d   = 10'd0;
               state_d = StWrBusy;
            end
            StWrBusy: begin
               if (cnt_q + 10'd1 < 10'(BUSY_BYTES)) begin
                  tx_d  = 8'h00;
                  cnt_d = cnt_q + 10'd1;
               end else begin
                  wr_cnt_d = wr_cnt_q + 16'd1;
                  state_d  = StHunt;
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StHunt;
         bit_cnt_q  <= 3'd0;
         rx_sr_q    <= 7'd0;
         tx_q       <= 8'hFF;
         miso_q     <= 1'b1;
         cnt_q      <= 10'd0;
         cmd_q      <= 6'd0;
         last_cmd_q <= 6'd0;
         arg_q      <= 32'd0;
         r1_q       <= 8'd0;
         idle_q     <= 1'b1;
         init_q     <= 1'b0;
         acmd_q     <= 1'b0;
         tries_q    <= 8'd0;
         rd_cnt_q   <= 16'd0;
         wr_cnt_q   <= 16'd0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_sr_q    <= rx_sr_d;
         tx_q       <= tx_d;
         miso_q     <= miso_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         last_cmd_q <= last_cmd_d;
         arg_q      <= arg_d;
         r1_q       <= r1_d;
         idle_q     <= idle_d;
         init_q     <= init_d;
         acmd_q     <= acmd_d;
         tries_q    <= tries_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   assign sd_miso_o    = miso_q;
   assign init_done_o  = init_q;
   assign last_cmd_o   = last_cmd_q;
   assign rd_blk_cnt_o = rd_cnt_q;
   assign wr_blk_cnt_o = wr_cnt_q;

endmodule
